dspl_drv: RTL
=============

DSPL_DRV -- requirements
Module: dspl_drv

Interface
REQ-001 SHALL have parameter REFRESH_CYCLES, default 100000, clk cycles per digit slot (1 ms at 100 MHz); legal range 4..2^20.
REQ-002 SHALL have parameter BLANK_CYCLES, default 1000, leading cycles of each slot with all digits off; legal range 1..REFRESH_CYCLES-2.
REQ-003 SHALL have port clk  input  1  100 MHz reference clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports d1..d8  input  6 each  digit k (d1 = rightmost, anode 0): bit5 enable, bits4:1 hex value 0..F, bit0 decimal point (1 = lit).
REQ-006 SHALL have port an  output  8  anode select, active-low, bit i = display position i.
REQ-007 SHALL have port dec_ddp  output  8  cathodes, active-low: bit7..bit1 = segments a,b,c,d,e,f,g; bit0 = dp.

Function
REQ-008 SHALL keep slot counter cnt, 0..REFRESH_CYCLES-1, incrementing every cycle and wrapping to 0 after REFRESH_CYCLES-1.
REQ-009 SHALL keep 3-bit position idx; it increments on each cycle where cnt wraps, 7 wraps to 0.
REQ-010 SHALL keep an 8-entry, 6-bit snapshot; on every edge with cnt==0 and idx==0 (frame start), it loads all of d1..d8 simultaneously.
REQ-011 Between frame starts, input changes SHALL NOT affect an or dec_ddp; no tearing within a frame.
REQ-012 an and dec_ddp SHALL be registered, computed each edge from pre-edge cnt, idx and snapshot; one-cycle latency.
REQ-013 If cnt < BLANK_CYCLES: an <= 8'hFF, dec_ddp <= 8'hFF.
REQ-014 Else if snapshot[idx] enable = 1: an <= all ones except bit idx = 0; dec_ddp <= decoded snapshot[idx].
REQ-015 Else (entry disabled): an <= 8'hFF, dec_ddp <= 8'hFF; slot time still consumed.
REQ-016 Segment decode SHALL be the standard hex font (0-9, A, b, C, d, E, F), active-low; e.g. 0 -> 7'b0000001, 1 -> 7'b1001111, 8 -> 7'b0000000, A -> 7'b0001000, F -> 7'b0111000.
REQ-017 dec_ddp[0] SHALL be the inverse of snapshot[idx] bit0 when the digit is displayed.
REQ-018 At most one an bit SHALL be 0 in any cycle.
REQ-019 Since BLANK_CYCLES >= 1, a snapshot load always coincides with a blank output cycle.

Reset
REQ-020 While rst = 1: cnt = 0, idx = 0, snapshot entries = 6'h00, an = 8'hFF, dec_ddp = 8'hFF, asynchronously.
REQ-021 Reset asserted mid-slot or mid-frame SHALL abort the scan immediately; after release, the first edge is a frame start (snapshot load, blank output).

Verification (REFRESH_CYCLES=4, BLANK_CYCLES=1 unless noted)
REQ-022 Reset: assert rst mid-scan with a digit lit -> an = 8'hFF, dec_ddp = 8'hFF in the same cycle, without waiting for a clk edge.
REQ-023 Scan order: d1=6'h20 (en, 0), d2=6'h22 (en, 1), others 0, release reset:
- edge 1: blank.
- edges 2-4: an = 8'hFE, dec_ddp = 8'h03.
- edge 5: blank.
- edges 6-8: an = 8'hFD, dec_ddp = 8'h9F.
- edges 9-32: an = 8'hFF.
- edge 33: new frame.
REQ-024 Decode and dp: d8 = 6'h31 (en, 8, dp) -> during slot 7, an = 8'h7F, dec_ddp = 8'h00; d8 = 6'h3E (en, F, no dp) -> dec_ddp = 8'h71.
REQ-025 Snapshot: change d1 value from 0 to A mid-frame -> display stays 8'h03 until the next frame start, then shows 8'h11.
REQ-026 Disabled digit: d3 = 6'h1E (en = 0) -> an stays 8'hFF throughout slot 2; slot timing unchanged.
REQ-027 Defaults (100000/1000): each anode active for exactly 99000 consecutive cycles per 800000-cycle frame; one-hot-low check on every cycle.

Source files
------------

// File: rtl/dspl_drv.sv
// Eight-digit multiplexed seven-segment driver: per-frame input snapshot, fixed slot
// timing with a leading blank window, active-low anode and cathode outputs.
module dspl_drv #(
    parameter int REFRESH_CYCLES = 100000,
    parameter int BLANK_CYCLES   = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] d1,
    input  logic [5:0] d2,
    input  logic [5:0] d3,
    input  logic [5:0] d4,
    input  logic [5:0] d5,
    input  logic [5:0] d6,
    input  logic [5:0] d7,
    input  logic [5:0] d8,
    output logic [7:0] an,
    output logic [7:0] dec_ddp
);

    localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    // Standard active-low hex font, segment order a..g from MSB to LSB.
    function automatic logic [6:0] seg_decode(input logic [3:0] val);
        logic [6:0] seg;
        case (val)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            4'hF:    seg = 7'b0111000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    logic [CW-1:0] cnt_r;
    logic [2:0]    idx_r;
    logic [5:0]    snap_r [8];
    logic [7:0]    an_r;
    logic [7:0]    dec_r;

    logic [5:0]    din_s [8];
    logic          cnt_wrap_s;
    logic          frame_start_s;
    logic [5:0]    cur_s;
    logic [7:0]    an_s;
    logic [7:0]    dec_s;

    assign din_s[0] = d1;
    assign din_s[1] = d2;
    assign din_s[2] = d3;
    assign din_s[3] = d4;
    assign din_s[4] = d5;
    assign din_s[5] = d6;
    assign din_s[6] = d7;
    assign din_s[7] = d8;

    assign cnt_wrap_s    = (cnt_r == CNT_MAX);
    assign frame_start_s = (cnt_r == {CW{1'b0}}) && (idx_r == 3'd0);
    assign cur_s         = snap_r[idx_r];

    // Next anode/cathode pattern from the pre-edge slot position and snapshot.
    always_comb begin
        an_s  = 8'hFF;
        dec_s = 8'hFF;
        if (cnt_r < BLANK_END) begin
            an_s  = 8'hFF;
            dec_s = 8'hFF;
        end else if (cur_s[5]) begin
            an_s  = ~(8'h01 << idx_r);
            dec_s = {seg_decode(cur_s[4:1]), ~cur_s[0]};
        end else begin
            an_s  = 8'hFF;
            dec_s = 8'hFF;
        end
    end

    // Slot counter and digit position; the position advances on slot wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
            idx_r <= 3'd0;
        end else if (cnt_wrap_s) begin
            cnt_r <= {CW{1'b0}};
            idx_r <= idx_r + 3'd1;
        end else begin
            cnt_r <= cnt_r + CW'(1);
            idx_r <= idx_r;
        end
    end

    // Whole-frame snapshot so a frame never mixes old and new digit data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                snap_r[i] <= 6'h00;
            end
        end else if (frame_start_s) begin
            for (int i = 0; i < 8; i++) begin
                snap_r[i] <= din_s[i];
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                snap_r[i] <= snap_r[i];
            end
        end
    end

    // Registered outputs; reset forces every digit dark immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_r  <= 8'hFF;
            dec_r <= 8'hFF;
        end else begin
            an_r  <= an_s;
            dec_r <= dec_s;
        end
    end

    assign an      = an_r;
    assign dec_ddp = dec_r;

endmodule
